// File: rtl/right_shift_seq.sv
// Iterative log-stage right shifter with valid/ready handshakes.
// Each clock resolves one bit of the shift amount, LSB first, so every
// request takes exactly SW shift cycles whatever the amount.
module right_shift_seq #(
    parameter  int unsigned width = 8,
    localparam int unsigned SW    = $clog2(width)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [width-1:0] i_bits,
    input  logic [SW-1:0]    i_shift,
    input  logic             i_arith,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [width-1:0] o_bits
);

    localparam int unsigned EXT_W = 2 * width;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r, state_nxt;
    logic [width-1:0]   data_r, data_nxt;
    logic [SW-1:0]      shift_r, shift_nxt;
    logic [SW-1:0]      stage_r, stage_nxt;
    logic               fill_r, fill_nxt;
    logic               ready_r, ready_nxt;
    logic               valid_r, valid_nxt;
    logic [EXT_W-1:0]   ext_shifted;

    // State and datapath registers; outputs are flops, never input-derived.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            data_r  <= '0;
            shift_r <= '0;
            stage_r <= '0;
            fill_r  <= 1'b0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt;
            data_r  <= data_nxt;
            shift_r <= shift_nxt;
            stage_r <= stage_nxt;
            fill_r  <= fill_nxt;
            ready_r <= ready_nxt;
            valid_r <= valid_nxt;
        end
    end

    // Next-state, datapath update and registered-output decode.
    always_comb begin
        state_nxt   = state_r;
        data_nxt    = data_r;
        shift_nxt   = shift_r;
        stage_nxt   = stage_r;
        fill_nxt    = fill_r;
        // Fill bits sit above the data so a right shift pulls them in.
        ext_shifted = {{width{fill_r}}, data_r} >> (EXT_W'(1) << stage_r);

        case (state_r)
            IDLE: begin
                if (i_valid && ready_r) begin
                    data_nxt  = i_bits;
                    shift_nxt = i_shift;
                    fill_nxt  = i_arith & i_bits[width-1];
                    stage_nxt = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_r[stage_r]) begin
                    data_nxt = ext_shifted[width-1:0];
                end
                if (stage_r == SW'(SW - 1)) begin
                    stage_nxt = '0;
                    state_nxt = DONE;
                end else begin
                    stage_nxt = stage_r + SW'(1);
                end
            end
            DONE: begin
                if (o_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        ready_nxt = (state_nxt == IDLE);
        valid_nxt = (state_nxt == DONE);
    end

    assign i_ready = ready_r;
    assign o_valid = valid_r;
    assign o_bits  = data_r;

endmodule

// File: tb/tb_right_shift_seq.sv
// Self-checking bench for right_shift_seq at width 8 and width 6.
module tb_right_shift_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       i_valid8, i_ready8, i_arith8, o_valid8, o_ready8;
    logic [7:0] i_bits8, o_bits8;
    logic [2:0] i_shift8;

    logic       i_valid6, i_ready6, i_arith6, o_valid6, o_ready6;
    logic [5:0] i_bits6, o_bits6;
    logic [2:0] i_shift6;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    right_shift_seq #(.width(8)) dut8 (
        .clk(clk), .rst(rst),
        .i_valid(i_valid8), .i_ready(i_ready8), .i_bits(i_bits8),
        .i_shift(i_shift8), .i_arith(i_arith8),
        .o_valid(o_valid8), .o_ready(o_ready8), .o_bits(o_bits8)
    );

    right_shift_seq #(.width(6)) dut6 (
        .clk(clk), .rst(rst),
        .i_valid(i_valid6), .i_ready(i_ready6), .i_bits(i_bits6),
        .i_shift(i_shift6), .i_arith(i_arith6),
        .o_valid(o_valid6), .o_ready(o_ready6), .o_bits(o_bits6)
    );

    typedef struct {
        logic       w6;
        logic [7:0] b;
        logic [2:0] s;
        logic       a;
        logic [7:0] exp;
    } vec_t;

    // Reference: plain Verilog shift operators on the whole word.
    function automatic logic [7:0] ref8(input logic [7:0] b, input int unsigned s, input logic a);
        logic signed [7:0] sb;
        sb = b;
        sb = sb >>> s;
        return a ? sb : (b >> s);
    endfunction

    function automatic logic [7:0] ref6(input logic [5:0] b, input int unsigned s, input logic a);
        logic signed [5:0] sb;
        logic [5:0]        r;
        sb = b;
        sb = sb >>> s;
        r  = a ? sb : (b >> s);
        return {2'b00, r};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // One full request: fire, scramble inputs, time the latency, check, consume.
    task automatic run_req(input logic w6, input logic [7:0] b, input logic [2:0] s,
                           input logic a, input logic [7:0] exp, input string name);
        int         cyc;
        logic [7:0] got;
        check({name, " i_ready"}, w6 ? i_ready6 : i_ready8, 1);
        if (w6) begin
            i_bits6 = b[5:0]; i_shift6 = s; i_arith6 = a; i_valid6 = 1'b1;
        end else begin
            i_bits8 = b; i_shift8 = s; i_arith8 = a; i_valid8 = 1'b1;
        end
        @(posedge clk); #1;
        i_valid8 = 1'b0; i_valid6 = 1'b0;
        i_bits8  = 8'($urandom); i_shift8 = 3'($urandom); i_arith8 = 1'($urandom);
        i_bits6  = 6'($urandom); i_shift6 = 3'($urandom); i_arith6 = 1'($urandom);
        cyc = 0;
        while (!(w6 ? o_valid6 : o_valid8) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, cyc, 3);
        got = w6 ? {2'b00, o_bits6} : o_bits8;
        check({name, " bits"}, got, exp);
        if (w6) o_ready6 = 1'b1; else o_ready8 = 1'b1;
        @(posedge clk); #1;
        o_ready6 = 1'b0; o_ready8 = 1'b0;
        check({name, " o_valid drop"}, w6 ? o_valid6 : o_valid8, 0);
    endtask

    initial begin
        vec_t        tbl[12];
        vec_t        b2b[4];
        logic [7:0]  exp_q[$];
        logic [7:0]  e;
        logic [7:0]  rb;
        int          in_cyc[4];
        int          out_cyc[8];
        int          idx, nout, cyc;
        bit          spurious;

        tbl[0]  = '{1'b0, 8'hB4, 3'd3, 1'b0, 8'h16};
        tbl[1]  = '{1'b0, 8'hB4, 3'd3, 1'b1, 8'hF6};
        tbl[2]  = '{1'b0, 8'h80, 3'd7, 1'b1, 8'hFF};
        tbl[3]  = '{1'b0, 8'h80, 3'd0, 1'b1, 8'h80};
        tbl[4]  = '{1'b0, 8'h7F, 3'd7, 1'b1, 8'h00};
        tbl[5]  = '{1'b0, 8'hC3, 3'd1, 1'b0, 8'h61};
        tbl[6]  = '{1'b0, 8'hC3, 3'd1, 1'b1, 8'hE1};
        tbl[7]  = '{1'b0, 8'hFF, 3'd4, 1'b0, 8'h0F};
        tbl[8]  = '{1'b1, 8'h2A, 3'd7, 1'b1, 8'h3F};
        tbl[9]  = '{1'b1, 8'h2A, 3'd7, 1'b0, 8'h00};
        tbl[10] = '{1'b1, 8'h2A, 3'd3, 1'b1, 8'h3D};
        tbl[11] = '{1'b1, 8'h15, 3'd2, 1'b1, 8'h05};

        b2b[0] = '{1'b0, 8'h9C, 3'd2, 1'b1, 8'hE7};
        b2b[1] = '{1'b0, 8'h9C, 3'd2, 1'b0, 8'h27};
        b2b[2] = '{1'b0, 8'h41, 3'd6, 1'b0, 8'h01};
        b2b[3] = '{1'b0, 8'hF0, 3'd5, 1'b1, 8'hFF};

        i_valid8 = 1'b0; i_bits8 = '0; i_shift8 = '0; i_arith8 = 1'b0; o_ready8 = 1'b0;
        i_valid6 = 1'b0; i_bits6 = '0; i_shift6 = '0; i_arith6 = 1'b0; o_ready6 = 1'b0;

        // Reset values
        #2 rst = 1'b1;
        #1;
        check("reset o_valid8", o_valid8, 0);
        check("reset i_ready8", i_ready8, 1);
        check("reset o_bits8", o_bits8, 0);
        check("reset o_valid6", o_valid6, 0);
        check("reset i_ready6", i_ready6, 1);
        check("reset o_bits6", o_bits6, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_req(tbl[i].w6, tbl[i].b, tbl[i].s, tbl[i].a, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Backpressure with ignored i_valid pulses
        i_bits8 = 8'h5A; i_shift8 = 3'd2; i_arith8 = 1'b0; i_valid8 = 1'b1;
        @(posedge clk); #1;
        i_valid8 = 1'b0;
        cyc = 0;
        while (!o_valid8 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check("bp latency", cyc, 3);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d o_valid", k), o_valid8, 1);
            check($sformatf("bp%0d o_bits", k), o_bits8, 8'h16);
            check($sformatf("bp%0d i_ready", k), i_ready8, 0);
            i_valid8 = 1'(k % 2 == 0);
            i_bits8  = 8'($urandom);
            i_shift8 = 3'($urandom);
            @(posedge clk); #1;
        end
        i_valid8 = 1'b0;
        o_ready8 = 1'b1;
        @(posedge clk); #1;
        o_ready8 = 1'b0;
        check("bp consumed o_valid", o_valid8, 0);
        check("bp consumed i_ready", i_ready8, 1);
        spurious = 1'b0;
        repeat (5) begin @(posedge clk); #1; if (o_valid8 || !i_ready8) spurious = 1'b1; end
        check("bp no queued request", spurious, 0);

        // Back-to-back with i_valid and o_ready held high
        idx = 0; nout = 0;
        o_ready8 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (o_valid8) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("b2b out%0d", nout), o_bits8, e);
                end else begin
                    check("b2b unexpected output", 1, 0);
                end
                if (nout < 8) out_cyc[nout] = c;
                nout++;
            end
            if (i_ready8) begin
                if (idx < 4) begin
                    i_bits8 = b2b[idx].b; i_shift8 = b2b[idx].s; i_arith8 = b2b[idx].a;
                    i_valid8 = 1'b1;
                    exp_q.push_back(b2b[idx].exp);
                    in_cyc[idx] = c;
                    idx++;
                end else begin
                    i_valid8 = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        i_valid8 = 1'b0; o_ready8 = 1'b0;
        check("b2b accepted", idx, 4);
        check("b2b outputs", nout, 4);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b in period%0d", k), in_cyc[k+1] - in_cyc[k], 5);
            if (nout >= k + 2) check($sformatf("b2b out period%0d", k), out_cyc[k+1] - out_cyc[k], 5);
        end

        // Reset during SHIFT at stage 1
        i_bits8 = 8'hB4; i_shift8 = 3'd3; i_arith8 = 1'b1; i_valid8 = 1'b1;
        @(posedge clk); #1;
        i_valid8 = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst o_valid", o_valid8, 0);
        check("midrst i_ready", i_ready8, 1);
        check("midrst o_bits", o_bits8, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        spurious = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (o_valid8) spurious = 1'b1; end
        check("midrst no spurious o_valid", spurious, 0);
        run_req(1'b0, 8'h96, 3'd2, 1'b1, 8'hE5, "post-reset");

        // Random sweep of every shift value on both widths
        for (int s = 0; s < 8; s++) begin
            for (int a = 0; a < 2; a++) begin
                repeat (2) begin
                    rb = 8'($urandom);
                    run_req(1'b0, rb, 3'(s), 1'(a), ref8(rb, s, 1'(a)),
                            $sformatf("rnd8 b=%0h s=%0d a=%0d", rb, s, a));
                    rb = 8'($urandom_range(0, 63));
                    run_req(1'b1, rb, 3'(s), 1'(a), ref6(rb[5:0], s, 1'(a)),
                            $sformatf("rnd6 b=%0h s=%0d a=%0d", rb, s, a));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
